tx_frame_serializer: RTL and testbench
======================================

# tx_frame_serializer

Transmit-side framing stage directly upstream of the 100 MHz Manchester encoder. It accepts parallel data words over a ready/valid handshake and prepends a fixed sync pattern. It optionally appends a CRC-8, then presents the frame one bit at a time, MSB first, on the encoder's `bit_in`/`bit_valid`/`bit_ready` serial handshake.

## Interface
- `DATA_W`, 16: payload word width in bits (≥ 2).
- `SYNC_W`, 8: sync field width in bits (≥ 1).
- `SYNC_PATTERN`, 8'hA5: sync field value, `SYNC_W` bits, sent MSB first.

- `clk_sys`  in  1  100 MHz system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `word_in`  in  DATA_W  payload word.
- `word_valid`  in  1  payload valid.
- `word_ready`  out  1  serializer can accept a word.
- `bit_out`  out  1  serial bit to encoder `bit_in`.
- `bit_valid`  out  1  `bit_out` valid; drives encoder `bit_valid`.
- `bit_ready`  in  1  from encoder `bit_ready`.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse after the last bit of a frame is accepted.

## Operation
- FSM states: IDLE, SYNC, DATA, CRC. CRC exists only with `TX_CRC_EN`.
- IDLE:
  - `word_ready`=1, `bit_valid`=0.
  - On `word_valid && word_ready`, latch `word_in` into the shift register and load `bit_cnt`=SYNC_W-1.
  - Clear the CRC register to 8'h00 and go to SYNC.
- SYNC:
  - `bit_out` = SYNC_PATTERN[bit_cnt].
  - On each transfer (`bit_valid && bit_ready`), decrement `bit_cnt`.
  - On transfer with `bit_cnt`=0, load DATA_W-1 and go to DATA.
- DATA:
  - `bit_out` = shift register MSB. Each transfer shifts left and decrements.
  - Each transferred bit b updates the CRC: fb = crc[7]^b; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00). Polynomial is x^8+x^2+x+1, init 0, no reflection, no final XOR.
  - At `bit_cnt`=0: go to CRC (load 7) if `TX_CRC_EN`, else IDLE.
- CRC: `bit_out` = crc[bit_cnt]. The CRC register is frozen during this state. Transfer at `bit_cnt`=0 goes to IDLE.
- `bit_valid`=1 in every non-IDLE state.
- Handshake rule: once `bit_valid` is high, `bit_out` is held stable until the transfer. `bit_valid` never drops without a transfer, except on reset.
- `word_ready` is low in all non-IDLE states. Upstream holds its word.
- `frame_done` is registered and asserted for exactly the cycle in which the state is IDLE following the final transfer.
- Reset outputs: `word_ready`=0 during reset, then 1 from the first cycle after `rst` deasserts. `bit_valid`=0, `bit_out`=0, `busy`=0, `frame_done`=0.
- Reset mid-frame: the frame is abandoned. Outputs take their reset values in the cycle after `rst` is sampled high. No partial CRC is sent.
- `bit_ready` low stalls the FSM indefinitely with no state change.

## Timing
- Word accepted at edge N: at N+1, `bit_valid`=1 and `bit_out`=SYNC_PATTERN[SYNC_W-1].
- Frame length L = SYNC_W+DATA_W (+8 with CRC). Default with CRC: L=32 bits.
- With `bit_ready` permanently high, the bits go out in L consecutive cycles. Paced by the encoder (ready every 4 cycles), a frame takes ~4L cycles.
- Last transfer at edge M: at M+1, state is IDLE, `frame_done`=1, `word_ready`=1, `bit_valid`=0.
- A word presented then is accepted at M+1; its first bit is valid at M+2.
- Minimum inter-frame gap is one cycle with `bit_valid`=0. Minimum word period is L+1 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from `bit_ready` or `word_valid` to any output.

## Configuration
- `TX_CRC_EN` defined:
  - CRC state and 8-bit CRC register are present.
  - The frame is SYNC | DATA | CRC-8.
- `TX_CRC_EN` undefined:
  - No CRC logic.
  - DATA goes straight to IDLE after its last bit; the frame is SYNC | DATA.
  - `frame_done` timing is otherwise identical.

## Test plan
- Reset, then idle: `rst`=1 for 3 cycles, then release. Expect `word_ready`=0 during reset and 1 after release, with `bit_valid`=0, `busy`=0 and `frame_done`=0.
- Single frame, `bit_ready`=1, `TX_CRC_EN`, `word_in`=16'h0001: expect 32 consecutive bits 1010_0101, 0000_0000_0000_0001, 0000_0111 (CRC 8'h07). `frame_done` pulses 1 cycle after the last bit.
- Same frame without `TX_CRC_EN`, `word_in`=16'hBEEF: expect 24 bits 1010_0101, 1011_1110_1110_1111, then `bit_valid`=0 and `frame_done`=1.
- Backpressure: drive `bit_ready` with the encoder's 1-of-4 pattern plus random 10-cycle stalls. Expect `bit_out` stable while `bit_valid && !bit_ready`, and the bit sequence identical to the unstalled case.
- Back-to-back: hold `word_valid`=1 with 16'h1234 then 16'h5678. Expect the second word accepted in the `frame_done` cycle, and exactly one `bit_valid`=0 cycle between frames.
- Reset mid-frame: assert `rst` after the 10th transfer. Expect `bit_valid`=0 on the next cycle, and the next word to start cleanly with the sync field and CRC recomputed from 8'h00.

Source files
------------

// File: rtl/tx_frame_serializer.sv
// tx_frame_serializer
//   Frames parallel payload words for the downstream Manchester encoder.
//   Each accepted word goes out as SYNC | DATA (| CRC-8), MSB first, over a
//   bit-serial valid/ready handshake.
//
//   Optional feature macro: TX_CRC_EN
//     Defined:   appends a CRC-8 (x^8+x^2+x+1, init 0x00) after the payload.
//     Undefined: the frame is SYNC | DATA only, and no CRC logic is built.
//
// Ports
//   clk_sys     in   system clock (single domain)
//   rst         in   synchronous, active-high reset
//   word_in     in   payload word [DATA_W-1:0]
//   word_valid  in   payload valid
//   word_ready  out  high in IDLE once out of reset
//   bit_out     out  serial bit toward the encoder bit_in
//   bit_valid   out  bit_out valid (high in every non-IDLE state)
//   bit_ready   in   encoder ready
//   busy        out  a frame is in progress
//   frame_done  out  one-cycle pulse in the IDLE cycle after the last bit
module tx_frame_serializer #(
  parameter int                DATA_W       = 16,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [DATA_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy,
  output logic              frame_done
);

  // The bit counter must index the widest field (sync, data or the 8-bit CRC).
  localparam int MAXW  = (DATA_W > SYNC_W) ? ((DATA_W > 8) ? DATA_W : 8)
                                           : ((SYNC_W > 8) ? SYNC_W : 8);
  localparam int CNT_W = $clog2(MAXW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
`ifdef TX_CRC_EN
    CRC  = 2'd3,
`endif
    DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic               done_q, done_d;
  // Holds word_ready low through reset and releases it on the first
  // cycle after rst is sampled low.
  logic               init_q;
  logic [SYNC_W-1:0]  sync_shr;

  // Shifting instead of part-selecting keeps the index width independent
  // of the field width.
  assign sync_shr = SYNC_PATTERN >> cnt_q;

`ifdef TX_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic [7:0] crc_shr;
  assign crc_shr = crc_q >> cnt_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  // Outputs decode registered state only; bit_ready/word_valid never reach them.
  assign word_ready = init_q && (state_q == IDLE);
  assign bit_valid  = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

  always_comb begin
    bit_out = 1'b0;
    case (state_q)
      SYNC:    bit_out = sync_shr[0];
      DATA:    bit_out = sh_q[DATA_W-1];
`ifdef TX_CRC_EN
      CRC:     bit_out = crc_shr[0];
`endif
      default: bit_out = 1'b0;
    endcase
  end

  // Next state. bit_valid is high in every non-IDLE state, so bit_ready
  // alone signals a transfer there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
`ifdef TX_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (word_valid && word_ready) begin
          sh_d    = word_in;
          cnt_d   = CNT_W'(SYNC_W - 1);
`ifdef TX_CRC_EN
          crc_d   = 8'h00;
`endif
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (bit_ready) begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(DATA_W - 1);
            state_d = DATA;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (bit_ready) begin
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
`ifdef TX_CRC_EN
          crc_d = crc8_step(crc_q, sh_q[DATA_W-1]);
`endif
          if (cnt_q == '0) begin
`ifdef TX_CRC_EN
            cnt_d   = CNT_W'(7);
            state_d = CRC;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
`ifdef TX_CRC_EN
      // CRC register is not updated here, so the sent value stays frozen.
      CRC: begin
        if (bit_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
`ifdef TX_CRC_EN
      crc_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      init_q  <= 1'b1;
`ifdef TX_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// tb_tx_frame_serializer
//   Directed sequence with random payloads and random encoder backpressure.
//   Expected frames come from a reference built as a plain bit vector
//   {sync, word, crc}, where the CRC is obtained by polynomial long division
//   of word*x^8 by 0x107. Build with or without TX_CRC_EN.
module tb_tx_frame_serializer;

  localparam int                DATA_W   = 16;
  localparam int                SYNC_W   = 8;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 8'hA5;
`ifdef TX_CRC_EN
  localparam int L = SYNC_W + DATA_W + 8;
`else
  localparam int L = SYNC_W + DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              busy;
  logic              frame_done;

  int total = 0;
  int bad   = 0;

  tx_frame_serializer #(
    .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PAT)
  ) dut (
    .clk_sys(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC-8 as the remainder of word*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [DATA_W-1:0] w);
    logic [DATA_W+7:0] m;
    logic [DATA_W+7:0] poly;
    m    = {w, 8'h00};
    poly = {{(DATA_W-1){1'b0}}, 9'h107};
    for (int i = DATA_W + 7; i >= 8; i--)
      if (m[i]) m = m ^ (poly << (i - 8));
    return m[7:0];
  endfunction

  function automatic logic [63:0] frame_ref(input logic [DATA_W-1:0] w);
`ifdef TX_CRC_EN
    return 64'({SYNC_PAT, w, crc_ref(w)});
`else
    return 64'({SYNC_PAT, w});
`endif
  endfunction

  // Presents a word once word_ready is seen; afterwards the first sync bit
  // must already be valid. keep leaves word_valid asserted afterwards.
  task automatic send_word(input logic [DATA_W-1:0] w, input logic keep);
    int n;
    n = 0;
    while (word_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("word_ready_seen", 64'(word_ready), 64'(1));
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = keep;
    check("first_bit", 64'({bit_valid, bit_out, word_ready, busy}),
          64'({1'b1, SYNC_PAT[SYNC_W-1], 1'b0, 1'b1}));
  endtask

  // Collects L transferred bits. mode 0: ready every cycle; mode 1: encoder
  // pacing (1 of 4) plus random 10-cycle stalls. Ends on the cycle after
  // the last transfer.
  task automatic recv_frame(input logic [DATA_W-1:0] w, input int mode, input string tag);
    logic [63:0] got;
    int   n, cyc, stall, errs;
    logic prev_stall, prev_bit, br;
    got = '0; n = 0; cyc = 0; stall = 0; errs = 0;
    prev_stall = 1'b0; prev_bit = 1'b0;
    while (n < L && cyc < 4000) begin
      if (mode == 0) br = 1'b1;
      else if (stall > 0) begin br = 1'b0; stall--; end
      else if ($urandom_range(0, 15) == 0) begin br = 1'b0; stall = 9; end
      else br = (cyc % 4 == 3);
      bit_ready = br;
      if (prev_stall && bit_out !== prev_bit) errs++;
      if (bit_valid !== 1'b1 || word_ready !== 1'b0 || busy !== 1'b1 ||
          frame_done !== 1'b0) errs++;
      if (bit_valid && br) begin
        got = {got[62:0], bit_out};
        n++;
      end
      prev_stall = bit_valid && !br;
      prev_bit   = bit_out;
      @(posedge clk); #1;
      cyc++;
    end
    bit_ready = 1'b0;
    check($sformatf("%s_count", tag), 64'(n), 64'(L));
    check($sformatf("%s_bits", tag), got, frame_ref(w));
    check($sformatf("%s_handshake", tag), 64'(errs), 64'(0));
    check($sformatf("%s_done", tag), 64'({frame_done, bit_valid, word_ready, busy}),
          64'(4'b1010));
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    rst = 1'b1; word_valid = 1'b0; word_in = '0; bit_ready = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check("reset", 64'({word_ready, bit_valid, busy, frame_done, bit_out}), 64'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset", 64'({word_ready, bit_valid, busy, frame_done, bit_out}),
          64'(5'b10000));

    // Known frames
    send_word(16'h0001, 1'b0);
    recv_frame(16'h0001, 0, "w0001");
    @(posedge clk); #1;
    check("done_one_cycle", 64'({frame_done, word_ready}), 64'(2'b01));
    send_word(16'hBEEF, 1'b0);
    recv_frame(16'hBEEF, 0, "wBEEF");

    // Backpressure with random payloads
    for (int k = 0; k < 3; k++) begin
      w = DATA_W'($urandom());
      send_word(w, 1'b0);
      recv_frame(w, 1, $sformatf("bp%0d", k));
    end

    // Back-to-back: second word taken in the frame_done cycle
    send_word(16'h1234, 1'b1);
    recv_frame(16'h1234, 0, "b2b1");
    send_word(16'h5678, 1'b0);
    recv_frame(16'h5678, 0, "b2b2");

    // Reset after the 10th transfer
    w = DATA_W'($urandom());
    send_word(w, 1'b0);
    bit_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bit_ready = 1'b0;
    @(posedge clk); #1;
    check("midframe_rst", 64'({word_ready, bit_valid, busy, frame_done, bit_out}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("midframe_release", 64'({word_ready, bit_valid, busy, frame_done}),
          64'(4'b1000));
    w = DATA_W'($urandom());
    send_word(w, 1'b0);
    recv_frame(w, 1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
